// File: rtl/alarm_pkg.sv
// Shared types for the alarm audio back end.
package alarm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEEP_ON,
    S_BEEP_OFF,
    S_GAP,
    S_DONE
  } tone_state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Restartable square-wave divider: toggles tone every TONE_HALF enabled cycles.
module tone_divider #(
  parameter int unsigned TONE_HALF = 12500
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  input  logic en,
  output logic tone
);

  localparam int TW = $clog2(TONE_HALF) + 1;
  localparam logic [TW-1:0] HALF_LAST = TW'(TONE_HALF - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (restart) begin
      cnt_d  = '0;
      tone_d = 1'b1;
    end else if (en) begin
      if (cnt_q == HALF_LAST) begin
        cnt_d  = '0;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/alarm_tone_gen.sv
// Alarm buzzer driver: beep/burst cadence while aud_en is high, auto-silence after MAX_BURSTS.
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int unsigned TONE_HALF  = 12500,
  parameter int unsigned BEEP_ON    = 5_000_000,
  parameter int unsigned BEEP_OFF   = 5_000_000,
  parameter int unsigned BEEPS      = 4,
  parameter int unsigned GAP        = 25_000_000,
  parameter int unsigned MAX_BURSTS = 60
) (
  input  logic clk,
  input  logic rstn,
  input  logic aud_en,
  output logic aud_out,
  output logic amp_en,
  output logic timed_out
);

  localparam int unsigned PHASE_MAX = max3(BEEP_ON, BEEP_OFF, GAP);
  localparam int PW = $clog2(PHASE_MAX) + 1;
  localparam int BW = $clog2(BEEPS + 1);
  localparam int KW = (MAX_BURSTS == 0) ? 1 : $clog2(MAX_BURSTS + 1);

  localparam logic [PW-1:0] ON_LAST  = PW'(BEEP_ON - 1);
  localparam logic [PW-1:0] OFF_LAST = PW'(BEEP_OFF - 1);
  localparam logic [PW-1:0] GAP_LAST = PW'(GAP - 1);
  localparam logic [BW-1:0] BEEPS_C  = BW'(BEEPS);
  localparam logic [KW-1:0] BURSTS_C = KW'(MAX_BURSTS);

  tone_state_t   state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] beep_q, beep_d, beep_inc;
  logic [KW-1:0] burst_q, burst_d, burst_inc;
  logic          aud_out_q, aud_out_d;
  logic          amp_en_q, amp_en_d;
  logic          timed_out_q, timed_out_d;
  logic          tone_restart;
  logic          tone;

  assign beep_inc  = beep_q + BW'(1);
  assign burst_inc = burst_q + KW'(1);

  // Every transition into BEEP_ON also restarts the divider so each beep opens high.
  always_comb begin
    state_d      = state_q;
    phase_d      = '0;
    beep_d       = beep_q;
    burst_d      = burst_q;
    tone_restart = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aud_en) begin
          state_d      = S_BEEP_ON;
          beep_d       = '0;
          burst_d      = '0;
          tone_restart = 1'b1;
        end
      end
      S_BEEP_ON: begin
        if (phase_q == ON_LAST) begin
          beep_d  = beep_inc;
          state_d = (beep_inc == BEEPS_C) ? S_GAP : S_BEEP_OFF;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_BEEP_OFF: begin
        if (phase_q == OFF_LAST) begin
          state_d      = S_BEEP_ON;
          tone_restart = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_GAP: begin
        if (phase_q == GAP_LAST) begin
          beep_d = '0;
          if (MAX_BURSTS != 0) burst_d = burst_inc;
          if ((MAX_BURSTS != 0) && (burst_inc == BURSTS_C)) begin
            state_d = S_DONE;
          end else begin
            state_d      = S_BEEP_ON;
            tone_restart = 1'b1;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Releasing the request wins over any timer expiry in the same cycle.
    if (!aud_en) begin
      state_d      = S_IDLE;
      phase_d      = '0;
      beep_d       = '0;
      burst_d      = '0;
      tone_restart = 1'b0;
    end
  end

  always_comb begin
    aud_out_d   = (state_q == S_BEEP_ON) && tone;
    amp_en_d    = (state_q == S_BEEP_ON) || (state_q == S_BEEP_OFF) || (state_q == S_GAP);
    timed_out_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      beep_q      <= '0;
      burst_q     <= '0;
      aud_out_q   <= 1'b0;
      amp_en_q    <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      beep_q      <= beep_d;
      burst_q     <= burst_d;
      aud_out_q   <= aud_out_d;
      amp_en_q    <= amp_en_d;
      timed_out_q <= timed_out_d;
    end
  end

  tone_divider #(
    .TONE_HALF(TONE_HALF)
  ) u_tone_divider (
    .clk    (clk),
    .rstn   (rstn),
    .restart(tone_restart),
    .en     (state_q == S_BEEP_ON),
    .tone   (tone)
  );

  assign aud_out   = aud_out_q;
  assign amp_en    = amp_en_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Bench for alarm_tone_gen: directed tables, hand sequences and a randomized run against a cadence model.
module tb_alarm_tone_gen;

  localparam int T_HALF  = 2;
  localparam int T_ON    = 8;
  localparam int T_OFF   = 4;
  localparam int T_BEEPS = 2;
  localparam int T_GAP   = 6;
  localparam int T_MAXB  = 2;
  localparam int T_PER   = T_BEEPS * T_ON + (T_BEEPS - 1) * T_OFF + T_GAP;

  logic clk = 1'b0;
  logic rstn;
  logic aud_en;
  logic aud1, amp1, to1;
  logic aud2, amp2, to2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alarm_tone_gen #(
    .TONE_HALF(T_HALF), .BEEP_ON(T_ON), .BEEP_OFF(T_OFF),
    .BEEPS(T_BEEPS), .GAP(T_GAP), .MAX_BURSTS(T_MAXB)
  ) dut (
    .clk(clk), .rstn(rstn), .aud_en(aud_en),
    .aud_out(aud1), .amp_en(amp1), .timed_out(to1)
  );

  alarm_tone_gen #(
    .TONE_HALF(T_HALF), .BEEP_ON(T_ON), .BEEP_OFF(T_OFF),
    .BEEPS(T_BEEPS), .GAP(T_GAP), .MAX_BURSTS(0)
  ) dut_nolimit (
    .clk(clk), .rstn(rstn), .aud_en(aud_en),
    .aud_out(aud2), .amp_en(amp2), .timed_out(to2)
  );

  // Cadence model: mode 0 idle, 1 alarming (t = cycles since arming), 2 timed out.
  typedef struct {
    int mode;
    int t;
  } mdl_t;

  function automatic mdl_t mdlStep(mdl_t m, logic r, logic a, int maxb);
    mdl_t n;
    n = m;
    if (!r || !a) begin
      n.mode = 0;
      n.t    = 0;
    end else if (m.mode == 0) begin
      n.mode = 1;
      n.t    = 0;
    end else if (m.mode == 1) begin
      n.t = m.t + 1;
      if (maxb != 0 && n.t == maxb * T_PER) n.mode = 2;
    end
    return n;
  endfunction

  function automatic logic [2:0] mdlOut(mdl_t m);
    int pos, off;
    if (m.mode == 0) return 3'b000;
    if (m.mode == 2) return 3'b001;
    pos = m.t % T_PER;
    off = pos % (T_ON + T_OFF);
    if (pos < T_BEEPS * (T_ON + T_OFF) && off < T_ON)
      return {((off / T_HALF) % 2 == 0) ? 1'b1 : 1'b0, 2'b10};
    return 3'b010;
  endfunction

  mdl_t       m1 = '{0, 0};
  mdl_t       m2 = '{0, 0};
  logic [2:0] exp1 = 3'b000;
  logic [2:0] exp2 = 3'b000;
  logic       valid = 1'b0;

  always @(posedge clk) begin
    exp1  <= mdlOut(m1);
    exp2  <= mdlOut(m2);
    valid <= rstn;
    m1    <= mdlStep(m1, rstn, aud_en, T_MAXB);
    m2    <= mdlStep(m2, rstn, aud_en, 0);
  end

  task automatic checkOutput(input string name, input logic [2:0] act,
                             input logic [2:0] exp, input logic [2:0] mask);
    if (mask == 3'b000) return;
    checks++;
    if (((act ^ exp) & mask) !== 3'b000) begin
      failures++;
      $display("[TB] FAIL %s: aud/amp/to actual=%b required=%b (mask %b) at %0t",
               name, act, exp, mask, $time);
    end
  endtask

  always @(negedge clk) begin
    if (valid) begin
      checkOutput("model_limited", {aud1, amp1, to1}, exp1, 3'b111);
      checkOutput("model_unlimited", {aud2, amp2, to2}, exp2, 3'b111);
    end
  end

  // Drive one edge's inputs, then return at the following negedge.
  task automatic applyStimulus(input logic r, input logic a);
    rstn   = r;
    aud_en = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic       rstn;
    logic       aud_en;
    logic [2:0] exp;
    logic [2:0] mask;
  } vec_t;

  vec_t vecs[$];

  task automatic loadTable(input string en_s, input string rst_s, input string aud_s,
                           input string amp_s, input string to_s);
    vec_t v;
    vecs.delete();
    for (int i = 0; i < en_s.len(); i++) begin
      v.aud_en = (en_s.substr(i, i) == "1");
      v.rstn   = (rst_s.substr(i, i) == "1");
      v.exp    = {aud_s.substr(i, i) == "1", amp_s.substr(i, i) == "1", to_s.substr(i, i) == "1"};
      v.mask   = {aud_s.substr(i, i) != "x", amp_s.substr(i, i) != "x", to_s.substr(i, i) != "x"};
      vecs.push_back(v);
    end
  endtask

  task automatic runTable(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rstn, vecs[i].aud_en);
      checkOutput($sformatf("%s[%0d]", name, i), {aud1, amp1, to1}, vecs[i].exp, vecs[i].mask);
    end
  endtask

  task automatic goIdle();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
  endtask

  initial begin
    int to_seen;
    rstn   = 1'b0;
    aud_en = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_state", {aud1, amp1, to1}, 3'b000, 3'b111);
    checkOutput("reset_state_nolimit", {aud2, amp2, to2}, 3'b000, 3'b111);
    goIdle();

    // First burst plus the first cycle of the second, cycles 0..27.
    loadTable("1111111111111111111111111111",
              "1111111111111111111111111111",
              "0110011000000110011000000001",
              "0111111111111111111111111111",
              "0000000000000000000000000000");
    runTable("burst1");

    // Keep holding into DONE; it must stay there while aud_en is high.
    for (int cyc = 28; cyc <= 60; cyc++) begin
      applyStimulus(1'b1, 1'b1);
      if (cyc == 52) checkOutput("last_gap_cycle", {aud1, amp1, to1}, 3'b010, 3'b111);
      if (cyc >= 53) checkOutput($sformatf("done_hold_c%0d", cyc), {aud1, amp1, to1}, 3'b001, 3'b111);
    end

    // One-cycle release from DONE then re-arm.
    loadTable("0111", "1111", "0011", "0011", "1000");
    runTable("rearm");
    goIdle();

    // Mid-beep release at cycle 5, re-raise at cycle 10.
    loadTable("111110000011", "111111111111",
              "011001000001", "011111000001", "000000000000");
    runTable("midbeep_drop");
    goIdle();

    // Reset edges 15..17 with aud_en held high, released at edge 18.
    loadTable("11111111111111111111",
              "11111111111111100011",
              "011001100000011x0001",
              "011111111111111x0001",
              "000000000000000x0000");
    runTable("reset_midbeep");
    goIdle();

    // Randomized segments of aud_en with sporadic resets, checked by the model.
    for (int s = 0; s < 14; s++) begin
      logic a;
      int   len;
      a   = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 70);
      for (int k = 0; k < len; k++)
        applyStimulus(($urandom_range(0, 59) != 0), a);
    end
    goIdle();

    // Unlimited bursts: never times out, cadence repeats every burst period.
    to_seen = 0;
    for (int c = 0; c < 200; c++) begin
      applyStimulus(1'b1, 1'b1);
      if (to2 !== 1'b0) to_seen++;
      if ((c % T_PER) == 1)
        checkOutput($sformatf("nolimit_beep_c%0d", c), {aud2, amp2, to2}, 3'b110, 3'b111);
      if ((c % T_PER) == 21)
        checkOutput($sformatf("nolimit_gap_c%0d", c), {aud2, amp2, to2}, 3'b010, 3'b111);
    end
    checks++;
    if (to_seen != 0) begin
      failures++;
      $display("[TB] FAIL nolimit_timed_out: high cycles actual=%0d required=0", to_seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
